// File: rtl/spi_boot_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package spi_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT,
    GAP,
    WRITE,
    FINISH
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  // Byte address of word idx relative to base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/spi_master_rx_byte.sv
// Receives one SPI mode-0 byte, MSB first: 16 sck half-periods of CLK_DIV clk cycles each.
module spi_master_rx_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sck
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       edge_cnt;
  logic             tick;

  assign tick = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Combinational so the caller leaves SHIFT exactly on the 8th falling edge.
  assign done = tick && (edge_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sck      <= 1'b0;
      rx_byte  <= '0;
    end else if (go && !active) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sck      <= 1'b0;
    end else if (active) begin
      if (tick) begin
        div_cnt  <= '0;
        sck      <= ~sck;
        edge_cnt <= edge_cnt + 4'd1;
        if (!sck) rx_byte <= {rx_byte[6:0], miso};
        if (edge_cnt == 4'd15) active <= 1'b0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_boot_loader.sv
// Copies word_count little-endian words from SPI flash (one byte per ss frame)
// into on-chip memory through a req/gnt write port.
module spi_boot_loader
  import spi_boot_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  output logic             ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [3:0] GAP_LAST = 4'(SS_GAP - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W:0]   idx_next;
  logic [1:0]       byte_idx;
  logic [31:0]      base_q;
  logic [31:0]      word_q;
  logic [3:0]       gap_cnt;
  logic             gap_end;
  logic             word_full;
  logic             last_word;
  logic             rx_go;
  logic             rx_done;
  logic [7:0]       rx_byte;

  spi_master_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (rx_go),
    .miso    (miso),
    .done    (rx_done),
    .rx_byte (rx_byte),
    .sck     (sck)
  );

  assign idx_next  = {1'b0, word_idx} + (CNT_W + 1)'(1);
  assign last_word = (idx_next == {1'b0, count_q});
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign word_full = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign ss        = !((state == SELECT) || (state == SHIFT));
  assign mosi      = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    rx_go   = 1'b0;
    case (state)
      IDLE:    if (start) state_n = (word_count == '0) ? FINISH : SELECT;
      SELECT: begin
        rx_go   = 1'b1;
        state_n = SHIFT;
      end
      SHIFT:   if (rx_done) state_n = GAP;
      GAP:     if (gap_end) state_n = word_full ? WRITE : SELECT;
      WRITE:   if (mem_gnt) state_n = last_word ? FINISH : SELECT;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count_q   <= '0;
      base_q    <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_q    <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          count_q  <= word_count;
          base_q   <= base_addr & ~32'h3;
          word_idx <= '0;
          byte_idx <= '0;
        end
        SHIFT: if (rx_done) begin
          word_q[{byte_idx, 3'b000} +: BYTE_W] <= rx_byte;
          gap_cnt <= '0;
        end
        GAP: if (gap_end) begin
          byte_idx <= byte_idx + 2'd1;
          // Address and data are frozen here and held for the whole request.
          if (word_full) begin
            mem_req   <= 1'b1;
            mem_addr  <= word_addr(base_q, 32'(word_idx));
            mem_wdata <= word_q;
          end
        end else begin
          gap_cnt <= gap_cnt + 4'd1;
        end
        WRITE: if (mem_gnt) begin
          mem_req  <= 1'b0;
          word_idx <= word_idx + CNT_W'(1);
        end
        FINISH: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: flash model, write scoreboard, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_spi_boot_loader;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             start2 = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic [31:0]      base_addr = '0;
  logic             busy, done, mem_req, ss, sck, mosi;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_gnt = 1'b0;
  logic             miso = 1'b0;
  logic             busy2, done2, mem_req2, ss2, sck2, mosi2;
  logic [31:0]      mem_addr2, mem_wdata2;
  logic             miso2 = 1'b0;

  always #5 clk = ~clk;

  spi_boot_loader #(.CLK_DIV(4), .SS_GAP(2), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_boot_loader #(.CLK_DIV(1), .SS_GAP(2), .CNT_W(CNT_W)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start2), .word_count(word_count), .base_addr(base_addr),
    .busy(busy2), .done(done2), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_gnt(1'b1), .ss(ss2), .sck(sck2), .mosi(mosi2), .miso(miso2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard and flash contents, filled when a transfer is launched.
  logic [63:0] exp_q[$];
  logic [7:0]  flash_q[$];
  int          stall_word = -1;
  int          stall_cycles = 0;
  int          wr_base = 0;

  int          frames = 0, rises = 0, bad_sck = 0, dones = 0, writes = 0;
  int          bit_idx = 0, stall_run = 0;
  logic        ss_prev = 1'b1, sck_prev = 1'b0, req_prev = 1'b0, gnt_prev = 1'b0;
  logic [31:0] addr_prev = '0, data_prev = '0;
  logic [7:0]  cur_byte = '0;
  logic [63:0] sb_entry;

  always @(negedge clk) begin
    if (!ss && ss_prev) begin
      frames++;
      if (flash_q.size() > 0) cur_byte = flash_q.pop_front();
      else                    cur_byte = 8'h00;
      bit_idx = 0;
    end
    if (sck && !sck_prev) begin
      rises++;
      bit_idx++;
      if (ss || mem_req) bad_sck++;
    end
    miso = (!ss && bit_idx < 8) ? cur_byte[7 - bit_idx] : 1'b0;
    if (done) dones++;
    if (mem_req && req_prev && !gnt_prev) begin
      chk("stall_addr_stable", mem_addr, addr_prev);
      chk("stall_data_stable", mem_wdata, data_prev);
    end
    if (mem_req) begin
      if ((writes - wr_base) == stall_word && stall_run < stall_cycles) begin
        mem_gnt = 1'b0;
        stall_run++;
      end else begin
        mem_gnt = 1'b1;
        stall_run = 0;
        writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", mem_addr, mem_wdata);
        end else begin
          sb_entry = exp_q.pop_front();
          chk("write_addr", mem_addr, sb_entry[63:32]);
          chk("write_data", mem_wdata, sb_entry[31:0]);
        end
      end
    end else begin
      mem_gnt = 1'b0;
    end
    ss_prev = ss; sck_prev = sck; req_prev = mem_req; gnt_prev = mem_gnt;
    addr_prev = mem_addr; data_prev = mem_wdata;
  end

  // Fast instance (CLK_DIV=1): frame timing monitor and fixed flash word.
  logic [31:0] fast_word = 32'hC3A55A3C;
  int          cyc2 = 0, fr2 = 0, bit2 = 0, wr2 = 0;
  int          fall2[4];
  int          low2[4];
  logic        ss2_prev = 1'b1, sck2_prev = 1'b0;
  logic [31:0] wa2 = '0, wd2 = '0;

  always @(negedge clk) begin
    cyc2++;
    if (!ss2 && ss2_prev) begin
      if (fr2 < 4) begin fall2[fr2] = cyc2; low2[fr2] = 0; end
      fr2++;
      bit2 = 0;
    end
    if (!ss2 && fr2 >= 1 && fr2 <= 4) low2[fr2-1]++;
    if (sck2 && !sck2_prev) bit2++;
    miso2 = (!ss2 && fr2 >= 1 && fr2 <= 4 && bit2 < 8) ? fast_word[8*(fr2-1) + 7 - bit2] : 1'b0;
    if (mem_req2) begin wr2++; wa2 = mem_addr2; wd2 = mem_wdata2; end
    ss2_prev = ss2; sck2_prev = sck2;
  end

  typedef struct {
    int          count;
    logic [31:0] base;
    logic [31:0] first_addr;
    logic [7:0]  seed;
    logic [7:0]  step;
    int          stall_word;
    int          stall_cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic launch(input int count, input logic [31:0] base, input logic [31:0] first_addr,
                        input logic [7:0] seed, input logic [7:0] step);
    logic [31:0] d;
    logic [7:0]  v;
    for (int w = 0; w < count; w++) begin
      d = '0;
      for (int b = 0; b < 4; b++) begin
        v = 8'(seed + (4*w + b) * step);
        flash_q.push_back(v);
        d[8*b +: 8] = v;
      end
      exp_q.push_back({first_addr + 32'(4*w), d});
    end
    @(negedge clk);
    start = 1'b1; word_count = CNT_W'(count); base_addr = base;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int limit, output int t);
    t = 0;
    while (!done && t < limit) begin @(negedge clk); t++; end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", t);
    end
  endtask

  task automatic run_xfer(input int count, input logic [31:0] base, input logic [31:0] first_addr,
                          input logic [7:0] seed, input logic [7:0] step);
    int f0, r0, d0, w0, b0, t;
    f0 = frames; r0 = rises; d0 = dones; w0 = writes; b0 = bad_sck;
    wr_base = writes;
    launch(count, base, first_addr, seed, step);
    wait_done(count * 300 + 50, t);
    if (count == 0) chk("zero_done_latency", t, 32'd1);
    repeat (3) @(negedge clk);
    chk("frames", frames - f0, 4 * count);
    chk("sck_rises", rises - r0, 32 * count);
    chk("done_pulses", dones - d0, 32'd1);
    chk("writes", writes - w0, count);
    chk("sck_while_idle_or_write", bad_sck - b0, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("busy_low_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int f0, d0, w0, t;
    vecs[0] = '{1, 32'h0000_0100, 32'h0000_0100, 8'h01, 8'h01, -1, 0};
    vecs[1] = '{3, 32'h0000_0200, 32'h0000_0200, 8'hA0, 8'h07,  1, 5};
    vecs[2] = '{0, 32'h0000_0300, 32'h0000_0300, 8'h00, 8'h00, -1, 0};
    vecs[3] = '{2, 32'h0000_0403, 32'h0000_0400, 8'h11, 8'h22, -1, 0};
    vecs[4] = '{2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 8'hF0, 8'h35,  0, 2};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ss", {31'b0, ss}, 32'd1);
    chk("rst_sck", {31'b0, sck}, 32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      stall_word = vecs[i].stall_word;
      stall_cycles = vecs[i].stall_cycles;
      run_xfer(vecs[i].count, vecs[i].base, vecs[i].first_addr, vecs[i].seed, vecs[i].step);
    end
    stall_word = -1;
    stall_cycles = 0;

    // start while busy with a different base must be dropped
    f0 = frames; d0 = dones; w0 = writes;
    wr_base = writes;
    launch(2, 32'h0000_0500, 32'h0000_0500, 8'h3C, 8'h11);
    repeat (100) @(negedge clk);
    start = 1'b1; word_count = CNT_W'(1); base_addr = 32'h0000_0900;
    @(negedge clk);
    start = 1'b0;
    wait_done(700, t);
    repeat (3) @(negedge clk);
    chk("busy_start_frames", frames - f0, 32'd8);
    chk("busy_start_dones", dones - d0, 32'd1);
    chk("busy_start_writes", writes - w0, 32'd2);
    chk("busy_start_sb_empty", exp_q.size(), 32'd0);

    // reset asserted during the shift of byte 2
    f0 = frames; d0 = dones; w0 = writes;
    launch(2, 32'h0000_0600, 32'h0000_0600, 8'h77, 8'h01);
    t = 0;
    while ((frames - f0) < 3 && t < 1000) begin @(negedge clk); t++; end
    chk("reached_byte2", {31'b0, (frames - f0) >= 3}, 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", {31'b0, ss}, 32'd1);
    chk("abort_sck", {31'b0, sck}, 32'd0);
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    flash_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", dones - d0, 32'd0);
    chk("abort_no_write", writes - w0, 32'd0);
    run_xfer(1, 32'h0000_0700, 32'h0000_0700, 8'h5A, 8'h13);

    // CLK_DIV=1 instance: 19-cycle byte frames
    @(negedge clk);
    start2 = 1'b1; word_count = CNT_W'(1); base_addr = 32'h0000_0040;
    @(negedge clk);
    start2 = 1'b0;
    t = 0;
    while (!done2 && t < 300) begin @(negedge clk); t++; end
    chk("fast_done_seen", {31'b0, done2}, 32'd1);
    repeat (3) @(negedge clk);
    chk("fast_frames", fr2, 32'd4);
    chk("fast_frame_period_01", fall2[1] - fall2[0], 32'd19);
    chk("fast_frame_period_23", fall2[3] - fall2[2], 32'd19);
    chk("fast_ss_low_cycles", low2[0], 32'd17);
    chk("fast_writes", wr2, 32'd1);
    chk("fast_addr", wa2, 32'h0000_0040);
    chk("fast_data", wd2, 32'hC3A55A3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
